// File: rtl/spi_cs_sequencer.sv
// ---------------------------------------------------------------------------
// spi_cs_sequencer
//   Frames a multi-byte SPI transaction for spi_master. A host command of N
//   bytes opens an active-low chip select, streams N host write bytes into the
//   spi_master TX handshake one at a time, returns every received byte as a
//   single-cycle pulse, then closes chip select and enforces an idle gap.
//
//   Timing parameters are edge-to-edge distances on clk_i:
//     CS_SETUP_CYCLES : cs_n fall -> first m_tx_valid_o (write byte ready)
//     CS_HOLD_CYCLES  : last m_rx_valid_i -> cs_n rise
//     CS_IDLE_CYCLES  : cs_n rise -> done_o (next command accepted then)
//
// Ports
//   clk_i, reset_l_i            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_len_i       command request and byte count (clamped)
//   cmd_ready_o                 high in IDLE only
//   wr_data_i/wr_valid_i        host write byte stream
//   wr_ready_o                  high in FETCH only
//   rd_data_o/rd_valid_o        received byte, 1-cycle pulse
//   done_o                      1-cycle pulse at command completion
//   m_tx_byte_o/m_tx_valid_o    to spi_master TX
//   m_tx_ready_i                from spi_master TX
//   m_rx_byte_i/m_rx_valid_i    from spi_master RX
//   spi_cs_n_o                  chip select, active low
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cs_n high, waiting for a command
// SETUP   | cs_n low, counting setup time before first fetch
// FETCH   | waiting for the next host write byte
// SEND    | presenting the byte to spi_master until it is taken
// WAIT_RX | waiting for spi_master to return the received byte
// HOLD    | last byte received, counting hold time with cs_n low
// GAP     | cs_n high, counting minimum idle time before done_o
// ---------------------------------------------------------------------------
module spi_cs_sequencer #(
  parameter int MAX_BYTES       = 16,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int CS_IDLE_CYCLES  = 1,
  localparam int LEN_W          = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk_i,
  input  logic             reset_l_i,
  input  logic             cmd_valid_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic             done_o,
  output logic [7:0]       m_tx_byte_o,
  output logic             m_tx_valid_o,
  input  logic             m_tx_ready_i,
  input  logic [7:0]       m_rx_byte_i,
  input  logic             m_rx_valid_i,
  output logic             spi_cs_n_o
);

  // SETUP and HOLD each add one cycle of their own on top of the FETCH/
  // WAIT_RX cycle that precedes the measured edge, so they dwell N-1 cycles
  // and are skipped entirely when N is 1. GAP dwells the full N cycles.
  localparam int SETUP_LOAD = (CS_SETUP_CYCLES >= 2) ? CS_SETUP_CYCLES - 2 : 0;
  localparam int HOLD_LOAD  = (CS_HOLD_CYCLES  >= 2) ? CS_HOLD_CYCLES  - 2 : 0;
  localparam int GAP_LOAD   = (CS_IDLE_CYCLES  >= 1) ? CS_IDLE_CYCLES  - 1 : 0;
  localparam int CNT_MAX    = (SETUP_LOAD > HOLD_LOAD) ?
                              ((SETUP_LOAD > GAP_LOAD) ? SETUP_LOAD : GAP_LOAD) :
                              ((HOLD_LOAD  > GAP_LOAD) ? HOLD_LOAD  : GAP_LOAD);
  localparam int CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE, SETUP, FETCH, SEND, WAIT_RX, HOLD, GAP
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cs_n_q, cs_n_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q, done_d;

  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      cnt_q      <= '0;
      cs_n_q     <= 1'b1;
      tx_byte_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      cs_n_q     <= cs_n_d;
      tx_byte_q  <= tx_byte_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    cs_n_d     = cs_n_q;
    tx_byte_d  = tx_byte_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d  = (cmd_len_i > MAX_LEN) ? MAX_LEN : cmd_len_i;
            cs_n_d = 1'b0;
            if (CS_SETUP_CYCLES >= 2) begin
              state_d = SETUP;
              cnt_d   = CNT_W'(SETUP_LOAD);
            end else begin
              state_d = FETCH;
            end
          end
        end
      end

      SETUP: begin
        if (cnt_q == '0) state_d = FETCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      FETCH: begin
        if (wr_valid_i) begin
          tx_byte_d = wr_data_i;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (m_tx_ready_i) state_d = WAIT_RX;
      end

      WAIT_RX: begin
        if (m_rx_valid_i) begin
          rd_data_d  = m_rx_byte_i;
          rd_valid_d = 1'b1;
          rem_d      = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            if (CS_HOLD_CYCLES >= 2) begin
              state_d = HOLD;
              cnt_d   = CNT_W'(HOLD_LOAD);
            end else begin
              cs_n_d  = 1'b1;
              state_d = GAP;
              cnt_d   = CNT_W'(GAP_LOAD);
            end
          end else begin
            state_d = FETCH;
          end
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_LOAD);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign wr_ready_o   = (state_q == FETCH);
  assign m_tx_valid_o = (state_q == SEND);
  assign m_tx_byte_o  = tx_byte_q;
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign done_o       = done_q;
  assign spi_cs_n_o   = cs_n_q;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
module tb_spi_cs_sequencer;

  localparam int MAX_BYTES       = 16;
  localparam int CS_SETUP_CYCLES = 2;
  localparam int CS_HOLD_CYCLES  = 2;
  localparam int CS_IDLE_CYCLES  = 1;
  localparam int LEN_W           = $clog2(MAX_BYTES + 1);
  localparam int BOUND           = 200;

  logic             clk_i = 1'b0;
  logic             reset_l_i;
  logic             cmd_valid_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             cmd_ready_o;
  logic [7:0]       wr_data_i;
  logic             wr_valid_i;
  logic             wr_ready_o;
  logic [7:0]       rd_data_o;
  logic             rd_valid_o;
  logic             done_o;
  logic [7:0]       m_tx_byte_o;
  logic             m_tx_valid_o;
  logic             m_tx_ready_i;
  logic [7:0]       m_rx_byte_i;
  logic             m_rx_valid_i;
  logic             spi_cs_n_o;

  spi_cs_sequencer #(
    .MAX_BYTES(MAX_BYTES),
    .CS_SETUP_CYCLES(CS_SETUP_CYCLES),
    .CS_HOLD_CYCLES(CS_HOLD_CYCLES),
    .CS_IDLE_CYCLES(CS_IDLE_CYCLES)
  ) dut (
    .clk_i(clk_i),
    .reset_l_i(reset_l_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_len_i(cmd_len_i),
    .cmd_ready_o(cmd_ready_o),
    .wr_data_i(wr_data_i),
    .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o),
    .done_o(done_o),
    .m_tx_byte_o(m_tx_byte_o),
    .m_tx_valid_o(m_tx_valid_o),
    .m_tx_ready_i(m_tx_ready_i),
    .m_rx_byte_i(m_rx_byte_i),
    .m_rx_valid_i(m_rx_valid_i),
    .spi_cs_n_o(spi_cs_n_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Event observer: counts and timestamps of externally visible events.
  int   n_fall = 0, n_rise = 0, n_done = 0, n_rd = 0, n_txhs = 0, n_bad = 0;
  int   last_fall_cyc = 0, last_rise_cyc = 0;
  logic prev_cs = 1'b1;

  always @(negedge clk_i) begin
    if (prev_cs === 1'b1 && spi_cs_n_o === 1'b0) begin n_fall++; last_fall_cyc = cyc; end
    if (prev_cs === 1'b0 && spi_cs_n_o === 1'b1) begin n_rise++; last_rise_cyc = cyc; end
    prev_cs = spi_cs_n_o;
    if (done_o)     n_done++;
    if (rd_valid_o) n_rd++;
    if (m_tx_valid_o && m_tx_ready_i) n_txhs++;
    if (spi_cs_n_o && (wr_ready_o || m_tx_valid_o)) n_bad++;
    if (!spi_cs_n_o && cmd_ready_o) n_bad++;
  end

  // Per-byte plan consumed by do_cmd.
  logic [7:0] wr_plan[$];
  logic [7:0] rx_plan[$];
  int         gap_plan[$];
  int         rdy_plan[$];
  int         rxd_plan[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic plan_byte(input logic [7:0] w, input logic [7:0] r,
                           input int g, input int rdy, input int rxd);
    wr_plan.push_back(w);
    rx_plan.push_back(r);
    gap_plan.push_back(g);
    rdy_plan.push_back(rdy);
    rxd_plan.push_back(rxd);
  endtask

  task automatic plan_random(input int n);
    for (int i = 0; i < n; i++)
      plan_byte(8'($urandom), 8'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  // Runs one command of len bytes; abort_at >= 0 resets the DUT while it
  // waits for that byte's receive data.
  task automatic do_cmd(input int len, input int abort_at);
    int nb, n, acc_cyc, rx_cyc, prev_rise;
    int fall0, rise0, done0, rd0, txhs0;
    int g, rdy, rxd;
    logic [7:0] b, r;
    logic ok;
    nb = (len > MAX_BYTES) ? MAX_BYTES : len;
    fall0 = n_fall; rise0 = n_rise; done0 = n_done; rd0 = n_rd; txhs0 = n_txhs;
    prev_rise = last_rise_cyc;
    rx_cyc = 0;

    n = 0;
    while (!cmd_ready_o && n < BOUND) begin tick(); n++; end
    check("cmd_ready_wait", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(len);
    acc_cyc     = cyc;
    tick();
    cmd_valid_i = 1'b0;
    cmd_len_i   = '0;
    check("cmd_ready_after_accept", cmd_ready_o, (nb == 0) ? 1 : 0);

    if (nb == 0) begin
      check("len0_done_next_cycle", done_o, 1);
      @(negedge clk_i); #1;
      check("len0_no_cs_fall", n_fall - fall0, 0);
      check("len0_no_tx", n_txhs - txhs0, 0);
      check("len0_single_done", n_done - done0, 1);
      return;
    end

    for (int i = 0; i < nb; i++) begin
      b = wr_plan.pop_front(); r = rx_plan.pop_front();
      g = gap_plan.pop_front(); rdy = rdy_plan.pop_front(); rxd = rxd_plan.pop_front();

      n = 0;
      while (!wr_ready_o && n < BOUND) begin tick(); n++; end
      check("wr_ready_wait", wr_ready_o, 1);
      // Write-side idle cycles, with stray receive strobes that must be ignored.
      for (int k = 0; k < g; k++) begin
        m_rx_valid_i = 1'($urandom);
        m_rx_byte_i  = 8'($urandom);
        tick();
      end
      m_rx_valid_i = 1'b0;
      check("wr_ready_holds", wr_ready_o, 1);
      wr_valid_i = 1'b1;
      wr_data_i  = b;
      tick();
      wr_valid_i = 1'b0;
      wr_data_i  = 8'($urandom);
      check("tx_valid_latency", m_tx_valid_o, 1);
      check("tx_byte", m_tx_byte_o, b);
      check("wr_ready_drop", wr_ready_o, 0);
      if (i == 0) begin
        check("cs_fall_after_accept", last_fall_cyc, acc_cyc + 1);
        check("setup_time", cyc - last_fall_cyc, CS_SETUP_CYCLES + g);
        if (prev_rise != 0)
          check("cs_idle_gap", ((last_fall_cyc - prev_rise) >= CS_IDLE_CYCLES), 1);
      end

      ok = 1'b1;
      for (int k = 0; k < rdy; k++) begin
        tick();
        if (m_tx_valid_o !== 1'b1 || m_tx_byte_o !== b) ok = 1'b0;
      end
      check("tx_stable_while_not_ready", ok, 1);
      m_tx_ready_i = 1'b1;
      tick();
      m_tx_ready_i = 1'b0;
      check("tx_valid_drop_after_ready", m_tx_valid_o, 0);

      if (i == abort_at) begin
        #2;
        reset_l_i = 1'b0;
        #1;
        check("abort_cs_high", spi_cs_n_o, 1);
        check("abort_rd_valid", rd_valid_o, 0);
        check("abort_wr_ready", wr_ready_o, 0);
        repeat (3) tick();
        reset_l_i = 1'b1;
        tick();
        check("abort_cmd_ready", cmd_ready_o, 1);
        check("abort_tx_byte_cleared", m_tx_byte_o, 0);
        check("abort_rd_data_cleared", rd_data_o, 0);
        wr_plan.delete(); rx_plan.delete(); gap_plan.delete();
        rdy_plan.delete(); rxd_plan.delete();
        return;
      end

      repeat (rxd) tick();
      m_rx_valid_i = 1'b1;
      m_rx_byte_i  = r;
      rx_cyc       = cyc;
      tick();
      m_rx_valid_i = 1'b0;
      m_rx_byte_i  = 8'($urandom);
      check("rd_valid_latency", rd_valid_o, 1);
      check("rd_data", rd_data_o, r);
    end

    n = 0;
    while (!done_o && n < BOUND) begin tick(); n++; end
    check("done_wait", done_o, 1);
    check("hold_time", last_rise_cyc - rx_cyc, CS_HOLD_CYCLES);
    check("idle_before_done", cyc - last_rise_cyc, CS_IDLE_CYCLES);
    check("cmd_ready_with_done", cmd_ready_o, 1);
    @(negedge clk_i); #1;
    check("single_cs_fall", n_fall - fall0, 1);
    check("single_cs_rise", n_rise - rise0, 1);
    check("single_done", n_done - done0, 1);
    check("rd_pulse_count", n_rd - rd0, nb);
    check("tx_handshake_count", n_txhs - txhs0, nb);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    reset_l_i    = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_len_i    = '0;
    wr_data_i    = '0;
    wr_valid_i   = 1'b0;
    m_tx_ready_i = 1'b0;
    m_rx_byte_i  = '0;
    m_rx_valid_i = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_cs_n", spi_cs_n_o, 1);
    check("rst_tx_valid", m_tx_valid_o, 0);
    check("rst_wr_ready", wr_ready_o, 0);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    check("rst_tx_byte", m_tx_byte_o, 0);
    reset_l_i = 1'b1;
    tick();
    check("cmd_ready_after_release", cmd_ready_o, 1);

    // Single byte A5 -> 3C
    plan_byte(8'hA5, 8'h3C, 0, 0, 2);
    do_cmd(1, -1);

    // Four bytes with alternating write gaps of 0 and 5
    for (int i = 0; i < 4; i++)
      plan_byte(8'(i + 1), 8'($urandom), (i % 2 == 1) ? 5 : 0, $urandom_range(0, 2), 1);
    do_cmd(4, -1);

    // Zero-length command
    do_cmd(0, -1);

    // Slow TX ready
    plan_byte(8'h5A, 8'hC3, 0, 10, 0);
    do_cmd(1, -1);

    // Over-length command clamps to MAX_BYTES
    plan_random(MAX_BYTES);
    do_cmd(MAX_BYTES + 4, -1);

    // Reset during WAIT_RX of a 3-byte command, then a normal command
    plan_random(3);
    do_cmd(3, 1);
    plan_byte(8'h81, 8'h18, 1, 1, 1);
    do_cmd(1, -1);

    // Randomized commands, issued back-to-back with the previous done_o
    repeat (25) begin
      len = $urandom_range(0, MAX_BYTES + 3);
      plan_random((len > MAX_BYTES) ? MAX_BYTES : len);
      do_cmd(len, -1);
    end

    repeat (4) tick();
    check("port_ownership", n_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
